// File: rtl/fifo_destino.sv
// Destination FIFO behind the VC-to-destination arbiter: in-order storage with
// registered one-cycle read data, occupancy flags and a sticky overflow/underflow flag.
module fifo_destino #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AFULL_TH   = 3,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  error_r;

  logic pop_ok_s;
  logic push_ok_s;
  logic fault_s;

  // Acceptance decode; a full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    fault_s   = 1'b0;
    if (pop && (count_r != CNT_ZERO)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((count_r != DEPTH_C) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if ((push && !push_ok_s) || (pop && !pop_ok_s)) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
  end

  // Storage array; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      error_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (fault_s) begin
        error_r <= 1'b1;
      end
    end
  end

  // Registered read port: data is forced to zero whenever it is not valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r <= DATA_ZERO;
      valid_r    <= 1'b0;
    end else if (pop_ok_s) begin
      data_out_r <= mem_r[rd_ptr_r];
      valid_r    <= 1'b1;
    end else begin
      data_out_r <= DATA_ZERO;
      valid_r    <= 1'b0;
    end
  end

  assign data_out       = data_out_r;
  assign data_out_valid = valid_r;
  assign count          = count_r;
  assign fifo_error     = error_r;
  assign fifo_full      = (count_r == DEPTH_C);
  assign fifo_empty     = (count_r == CNT_ZERO);
  assign almost_full    = (count_r >= AFULL_C);
  assign almost_empty   = (count_r <= AEMPTY_C);

endmodule
